packet_generator: RTL and testbench
===================================

PACKET_GENERATOR -- requirements
Module: packet_generator

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 64, stream data width in bits (multiple of 8, at least 16).
REQ-002 SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, bytes per beat.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, descriptor length width in bytes.
REQ-004 SHALL have parameter TAG_WIDTH, default 8, descriptor tag width.
REQ-005 SHALL have these ports (one clock, reset asynchronous active-low):
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 enable  in  1  permit new descriptor acceptance
 s_axis_desc_len  in  LEN_WIDTH  packet length in bytes
 s_axis_desc_tag  in  TAG_WIDTH  packet tag / pattern seed
 s_axis_desc_valid  in  1  descriptor valid
 s_axis_desc_ready  out  1  descriptor accepted when valid and ready
 m_axis_tdata  out  AXIS_DATA_WIDTH  packet data, little endian, byte 0 in bits [7:0]
 m_axis_tkeep  out  AXIS_KEEP_WIDTH  byte enables
 m_axis_tvalid  out  1  beat valid
 m_axis_tready  in  1  sink ready
 m_axis_tlast  out  1  last beat of packet
 m_axis_desc_status_len  out  LEN_WIDTH  completed length
 m_axis_desc_status_tag  out  TAG_WIDTH  completed tag
 m_axis_desc_status_error  out  1  descriptor rejected (zero length)
 m_axis_desc_status_valid  out  1  one-cycle completion pulse, no ready
 busy  out  1  state not IDLE
 stat_pkt_count  out  32  packets completed
 stat_byte_count  out  32  bytes completed

Function
REQ-006 SHALL implement states IDLE, SEND, STATUS.
REQ-007 s_axis_desc_ready SHALL be high only in IDLE with enable=1.
REQ-008 On descriptor accept with len>0: latch len/tag, beat count = ceil(len/AXIS_KEEP_WIDTH), go SEND; first beat valid the next cycle.
REQ-009 On accept with len=0: no beats; go STATUS with error=1.
REQ-010 Byte i of packet SHALL equal (tag + i) mod 256, counted from packet start.
REQ-011 Every beat but the last SHALL have tkeep all ones; last beat tkeep = low (len mod AXIS_KEEP_WIDTH) bits set, all ones when remainder is 0; tlast high only on last beat.
REQ-012 While tvalid=1 and tready=0, tdata, tkeep, tlast SHALL hold stable; tvalid SHALL not drop until handshake.
REQ-013 Beats SHALL advance one per cycle while tready=1 (no bubbles within a packet).
REQ-014 On last-beat handshake go STATUS; in STATUS pulse status_valid for exactly one cycle with latched len, tag, error, then go IDLE.
REQ-015 Minimum inter-packet gap: two cycles from last-beat handshake to next first beat.
REQ-016 enable deasserted mid-packet SHALL not affect the packet in flight; only blocks further acceptance.
REQ-017 Beat counter width SHALL be LEN_WIDTH - log2(AXIS_KEEP_WIDTH) + 1; len = 2^LEN_WIDTH-1 SHALL work.
REQ-018 When tvalid=0, tdata, tkeep and tlast SHALL be 0.

Reset
REQ-019 rst_n low SHALL immediately force state IDLE, all outputs and counters to 0; an in-flight packet is abandoned without tlast or status.
REQ-020 After rst_n release, descriptors SHALL be accepted from the first clock edge with enable=1.

Configuration
REQ-021 Macro PACKET_GENERATOR_STATS_EN defined: stat_pkt_count increments per non-error status, stat_byte_count adds len, both wrap modulo 2^32.
REQ-022 Macro absent: stat ports present and tied to 0, no counter logic.

Structure
REQ-023 Package packet_generator_pkg SHALL hold state encoding constants and the tkeep-from-remainder function.
REQ-024 Sub-module packet_pattern_gen SHALL produce one beat of pattern data from tag and beat index.

Verification (AXIS_DATA_WIDTH=64)
REQ-025 len=8 tag=0x10, tready=1 -> one beat tdata=0x1716151413121110, tkeep=0xFF, tlast=1; status len=8 tag=0x10 error=0 next cycle.
REQ-026 len=13 tag=0x10 -> beat0 tkeep=0xFF; beat1 tdata=0x000000_1C1B1A1918, tkeep=0x1F, tlast=1.
REQ-027 len=20, tready low 3 cycles at beat0 -> beat0 held stable 4 cycles, 3 beats total, final tkeep=0x0F.
REQ-028 len=0 tag=0x05 -> no tvalid; status_valid one cycle, error=1, tag=0x05.
REQ-029 rst_n low mid-beat1 of len=24 -> outputs 0 same cycle; next descriptor len=8 produces a clean single beat.
REQ-030 With PACKET_GENERATOR_STATS_EN, packets 8, 13, 20 plus one len=0 -> stat_pkt_count=3, stat_byte_count=41.

Source files
------------

// File: rtl/packet_generator_pkg.sv
// Shared types and helpers for the descriptor-driven packet generator.
// State encoding and the last-beat byte-enable function live here.
package packet_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_STATUS = 2'd2
    } state_t;

    localparam int KEEP_MAX = 256;

    // Low `rem` bits set; a zero remainder means a completely full beat.
    function automatic logic [KEEP_MAX-1:0] keep_from_rem(input int unsigned rem,
                                                          input int unsigned keep_w);
        logic [KEEP_MAX-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            k[i] = (i < keep_w) && ((rem == 0) || (i < rem));
        end
        return k;
    endfunction

endpackage

// File: rtl/packet_pattern_gen.sv
// One beat of incrementing-byte pattern data: byte j = tag + beat_idx*KEEP + j (mod 256).
module packet_pattern_gen
    import packet_generator_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int TAG_WIDTH       = 8,
    parameter int BEAT_W          = 14
) (
    input  logic [TAG_WIDTH-1:0]       tag,
    input  logic [BEAT_W-1:0]          beat_idx,
    output logic [AXIS_DATA_WIDTH-1:0] data
);

    logic [7:0] base;

    always_comb begin
        base = 8'(tag) + 8'(beat_idx * AXIS_KEEP_WIDTH);
        data = '0;
        for (int j = 0; j < AXIS_KEEP_WIDTH; j++) begin
            data[8*j +: 8] = base + 8'(j);
        end
    end

endmodule

// File: rtl/packet_generator.sv
// Descriptor-driven AXI-Stream packet generator with a one-cycle completion status.
// Define PACKET_GENERATOR_STATS_EN to build the packet/byte statistics counters.
//
//   state     | meaning
//   ST_IDLE   | waiting for a descriptor (ready when enable=1)
//   ST_SEND   | streaming beats; next beat loaded on each handshake
//   ST_STATUS | one-cycle completion pulse, then back to idle
module packet_generator
    import packet_generator_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int LEN_WIDTH       = 16,
    parameter int TAG_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [LEN_WIDTH-1:0]       s_axis_desc_len,
    input  logic [TAG_WIDTH-1:0]       s_axis_desc_tag,
    input  logic                       s_axis_desc_valid,
    output logic                       s_axis_desc_ready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [LEN_WIDTH-1:0]       m_axis_desc_status_len,
    output logic [TAG_WIDTH-1:0]       m_axis_desc_status_tag,
    output logic                       m_axis_desc_status_error,
    output logic                       m_axis_desc_status_valid,
    output logic                       busy,
    output logic [31:0]                stat_pkt_count,
    output logic [31:0]                stat_byte_count
);

    localparam int KEEP_LOG2 = $clog2(AXIS_KEEP_WIDTH);
    localparam int BEAT_W    = LEN_WIDTH - KEEP_LOG2 + 1;

    state_t                     state;
    logic [LEN_WIDTH-1:0]       len_q;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic [BEAT_W-1:0]          beats_left;
    logic [BEAT_W-1:0]          beat_idx;

    logic                       desc_fire;
    logic [LEN_WIDTH-1:0]       sel_len;
    logic [TAG_WIDTH-1:0]       sel_tag;
    logic [BEAT_W-1:0]          sel_idx;
    logic [LEN_WIDTH:0]         len_round;
    logic [BEAT_W-1:0]          beat_total;
    logic [KEEP_MAX-1:0]        keep_full;
    logic                       keep_unused;
    logic                       next_last;
    logic [AXIS_KEEP_WIDTH-1:0] next_keep;
    logic [AXIS_DATA_WIDTH-1:0] pattern;
    logic [AXIS_DATA_WIDTH-1:0] next_data;

    assign s_axis_desc_ready = rst_n && enable && (state == ST_IDLE);
    assign desc_fire         = s_axis_desc_valid && s_axis_desc_ready;
    assign busy              = (state != ST_IDLE);

    // In IDLE the next beat is beat 0 of the incoming descriptor; in SEND it follows the current one.
    always_comb begin
        sel_len    = (state == ST_IDLE) ? s_axis_desc_len : len_q;
        sel_tag    = (state == ST_IDLE) ? s_axis_desc_tag : tag_q;
        sel_idx    = (state == ST_IDLE) ? '0 : beat_idx + BEAT_W'(1);
        len_round  = {1'b0, sel_len} + (LEN_WIDTH+1)'(AXIS_KEEP_WIDTH - 1);
        beat_total = BEAT_W'(len_round / (LEN_WIDTH+1)'(AXIS_KEEP_WIDTH));
        keep_full  = keep_from_rem(32'(sel_len % LEN_WIDTH'(AXIS_KEEP_WIDTH)), AXIS_KEEP_WIDTH);
        next_last  = (state == ST_IDLE) ? (beat_total == BEAT_W'(1)) : (beats_left == BEAT_W'(2));
        next_keep  = next_last ? keep_full[AXIS_KEEP_WIDTH-1:0] : '1;
        next_data  = '0;
        for (int j = 0; j < AXIS_KEEP_WIDTH; j++) begin
            next_data[8*j +: 8] = next_keep[j] ? pattern[8*j +: 8] : 8'h00;
        end
    end

    assign keep_unused = ^keep_full[KEEP_MAX-1:AXIS_KEEP_WIDTH];

    packet_pattern_gen #(
        .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH),
        .AXIS_KEEP_WIDTH (AXIS_KEEP_WIDTH),
        .TAG_WIDTH       (TAG_WIDTH),
        .BEAT_W          (BEAT_W)
    ) u_pattern (
        .tag      (sel_tag),
        .beat_idx (sel_idx),
        .data     (pattern)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= ST_IDLE;
            len_q                    <= '0;
            tag_q                    <= '0;
            beats_left               <= '0;
            beat_idx                 <= '0;
            m_axis_tdata             <= '0;
            m_axis_tkeep             <= '0;
            m_axis_tvalid            <= 1'b0;
            m_axis_tlast             <= 1'b0;
            m_axis_desc_status_len   <= '0;
            m_axis_desc_status_tag   <= '0;
            m_axis_desc_status_error <= 1'b0;
            m_axis_desc_status_valid <= 1'b0;
        end else begin
            m_axis_desc_status_valid <= 1'b0;
            m_axis_desc_status_len   <= '0;
            m_axis_desc_status_tag   <= '0;
            m_axis_desc_status_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (desc_fire) begin
                        len_q <= s_axis_desc_len;
                        tag_q <= s_axis_desc_tag;
                        if (s_axis_desc_len == '0) begin
                            state                    <= ST_STATUS;
                            m_axis_desc_status_valid <= 1'b1;
                            m_axis_desc_status_tag   <= s_axis_desc_tag;
                            m_axis_desc_status_error <= 1'b1;
                        end else begin
                            state         <= ST_SEND;
                            beats_left    <= beat_total;
                            beat_idx      <= '0;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= next_data;
                            m_axis_tkeep  <= next_keep;
                            m_axis_tlast  <= next_last;
                        end
                    end
                end
                ST_SEND: begin
                    if (m_axis_tready) begin
                        if (m_axis_tlast) begin
                            state                    <= ST_STATUS;
                            m_axis_tvalid            <= 1'b0;
                            m_axis_tdata             <= '0;
                            m_axis_tkeep             <= '0;
                            m_axis_tlast             <= 1'b0;
                            m_axis_desc_status_valid <= 1'b1;
                            m_axis_desc_status_len   <= len_q;
                            m_axis_desc_status_tag   <= tag_q;
                        end else begin
                            beats_left   <= beats_left - BEAT_W'(1);
                            beat_idx     <= beat_idx + BEAT_W'(1);
                            m_axis_tdata <= next_data;
                            m_axis_tkeep <= next_keep;
                            m_axis_tlast <= next_last;
                        end
                    end
                end
                ST_STATUS: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

`ifdef PACKET_GENERATOR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkt_count  <= '0;
            stat_byte_count <= '0;
        end else if (m_axis_desc_status_valid && !m_axis_desc_status_error) begin
            stat_pkt_count  <= stat_pkt_count + 32'd1;
            stat_byte_count <= stat_byte_count + 32'(m_axis_desc_status_len);
        end
    end
`else
    assign stat_pkt_count  = '0;
    assign stat_byte_count = '0;
`endif

endmodule

// File: tb/tb_packet_generator.sv
// Self-checking bench for packet_generator (64-bit data) against a byte-level packet model.
module tb_packet_generator;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] s_axis_desc_len;
    logic [7:0]  s_axis_desc_tag;
    logic        s_axis_desc_valid;
    logic        s_axis_desc_ready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] m_axis_desc_status_len;
    logic [7:0]  m_axis_desc_status_tag;
    logic        m_axis_desc_status_error;
    logic        m_axis_desc_status_valid;
    logic        busy;
    logic [31:0] stat_pkt_count;
    logic [31:0] stat_byte_count;

    packet_generator #(
        .AXIS_DATA_WIDTH (64),
        .AXIS_KEEP_WIDTH (8),
        .LEN_WIDTH       (16),
        .TAG_WIDTH       (8)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .enable                   (enable),
        .s_axis_desc_len          (s_axis_desc_len),
        .s_axis_desc_tag          (s_axis_desc_tag),
        .s_axis_desc_valid        (s_axis_desc_valid),
        .s_axis_desc_ready        (s_axis_desc_ready),
        .m_axis_tdata             (m_axis_tdata),
        .m_axis_tkeep             (m_axis_tkeep),
        .m_axis_tvalid            (m_axis_tvalid),
        .m_axis_tready            (m_axis_tready),
        .m_axis_tlast             (m_axis_tlast),
        .m_axis_desc_status_len   (m_axis_desc_status_len),
        .m_axis_desc_status_tag   (m_axis_desc_status_tag),
        .m_axis_desc_status_error (m_axis_desc_status_error),
        .m_axis_desc_status_valid (m_axis_desc_status_valid),
        .busy                     (busy),
        .stat_pkt_count           (stat_pkt_count),
        .stat_byte_count          (stat_byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct packed { logic [15:0] len; logic [7:0] tag; } desc_t;
    typedef struct packed { logic [63:0] data; logic [7:0] keep; logic last; int cyc; } beat_t;
    typedef struct packed { logic [15:0] len; logic [7:0] tag; logic err; int cyc; } stat_t;

    desc_t dq[$];
    beat_t bq[$];
    stat_t sq[$];
    int    hold_err, zero_err, pulse_err, first_hold;
    bit    run_ok;
    int    checks = 0;
    int    errors = 0;

    // Reference model: byte i of a packet is (tag + i) mod 256; bytes past len are absent.
    function automatic logic [63:0] model_data(input int len, input int tag, input int beat);
        logic [63:0] d;
        d = '0;
        for (int j = 0; j < 8; j++) begin
            if (beat * 8 + j < len) d[8*j +: 8] = 8'((tag + beat * 8 + j) % 256);
        end
        return d;
    endfunction

    function automatic logic [7:0] model_keep(input int len, input int beat);
        logic [7:0] k;
        k = '0;
        for (int j = 0; j < 8; j++) k[j] = (beat * 8 + j < len);
        return k;
    endfunction

    function automatic int model_beats(input int len);
        return (len + 7) / 8;
    endfunction

    // Drives the descriptors in dq back to back and records every beat and status seen.
    task automatic run_descs(input int stall_pct, input int stall_first, input bit drop_enable,
                             input int budget);
        int          n_desc;
        int          low_left;
        bit          pend, prev_st, finishing, acc;
        logic [63:0] hd;
        logic [7:0]  hk;
        logic        hl;
        n_desc = dq.size();
        bq.delete();
        sq.delete();
        hold_err = 0; zero_err = 0; pulse_err = 0; first_hold = 0;
        low_left = stall_first; pend = 0; prev_st = 0; finishing = 0; run_ok = 0;
        hd = '0; hk = '0; hl = 0;
        if (dq.size() > 0) begin
            s_axis_desc_valid = 1'b1;
            s_axis_desc_len   = dq[0].len;
            s_axis_desc_tag   = dq[0].tag;
        end
        for (int c = 0; c < budget; c++) begin
            if (m_axis_tvalid && bq.size() == 0 && low_left > 0) begin
                m_axis_tready = 1'b0;
                low_left--;
            end else begin
                m_axis_tready = ($urandom_range(99) >= stall_pct);
            end
            @(negedge clk);
            if (m_axis_tvalid) begin
                if (bq.size() == 0) first_hold++;
                if (pend && (m_axis_tdata !== hd || m_axis_tkeep !== hk || m_axis_tlast !== hl))
                    hold_err++;
                if (m_axis_tready) begin
                    bq.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, cyc_cnt});
                    pend = 0;
                end else begin
                    pend = 1; hd = m_axis_tdata; hk = m_axis_tkeep; hl = m_axis_tlast;
                end
            end else begin
                if (pend) hold_err++;
                pend = 0;
                if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0) zero_err++;
            end
            if (m_axis_desc_status_valid) begin
                if (prev_st) pulse_err++;
                sq.push_back('{m_axis_desc_status_len, m_axis_desc_status_tag,
                               m_axis_desc_status_error, cyc_cnt});
            end
            prev_st = m_axis_desc_status_valid;
            if (finishing) begin
                run_ok = 1;
                break;
            end
            if (sq.size() >= n_desc) finishing = 1;
            acc = s_axis_desc_valid && s_axis_desc_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                void'(dq.pop_front());
                if (drop_enable) enable = 1'b0;
                if (dq.size() > 0) begin
                    s_axis_desc_len = dq[0].len;
                    s_axis_desc_tag = dq[0].tag;
                end else begin
                    s_axis_desc_valid = 1'b0;
                end
            end
        end
        s_axis_desc_valid = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (m_axis_tvalid !== 0 || m_axis_tdata !== 0 || m_axis_tkeep !== 0 || m_axis_tlast !== 0 ||
            m_axis_desc_status_valid !== 0 || busy !== 0 || s_axis_desc_ready !== 0 ||
            stat_pkt_count !== 0 || stat_byte_count !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got tvalid=%0b tdata=%0h tkeep=%0h ready=%0b busy=%0b stat=%0d/%0d expected all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, s_axis_desc_ready, busy,
                     stat_pkt_count, stat_byte_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_axis_desc_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got ready=%0b busy=%0b expected 1/0", s_axis_desc_ready, busy);
        end
        s_axis_desc_valid = 1'b1; s_axis_desc_len = 16'd8; s_axis_desc_tag = 8'h33;
        @(posedge clk);
        #1;
        s_axis_desc_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata[7:0] !== 8'h33) begin
            errors++;
            $display("FAIL first_edge_accept: got tvalid=%0b byte0=%0h expected 1/33", m_axis_tvalid, m_axis_tdata[7:0]);
        end
        m_axis_tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_single_beat();
        @(posedge clk); #1;
        dq.delete(); dq.push_back('{16'd8, 8'h10});
        run_descs(0, 0, 0, 50);
        checks++;
        if (!run_ok || bq.size() != 1 || sq.size() != 1) begin
            errors++;
            $display("FAIL single_counts: got ok=%0b beats=%0d status=%0d expected 1/1/1", run_ok, bq.size(), sq.size());
        end else begin
            checks++;
            if (bq[0].data !== 64'h1716151413121110 || bq[0].keep !== 8'hFF || bq[0].last !== 1'b1) begin
                errors++;
                $display("FAIL single_beat: got %0h/%0h/%0b expected 1716151413121110/ff/1", bq[0].data, bq[0].keep, bq[0].last);
            end
            checks++;
            if (sq[0].len !== 16'd8 || sq[0].tag !== 8'h10 || sq[0].err !== 1'b0 || sq[0].cyc - bq[0].cyc != 1) begin
                errors++;
                $display("FAIL single_status: got len=%0d tag=%0h err=%0b lat=%0d expected 8/10/0/1",
                         sq[0].len, sq[0].tag, sq[0].err, sq[0].cyc - bq[0].cyc);
            end
        end
    endtask

    task automatic test_partial_beat();
        @(posedge clk); #1;
        dq.delete(); dq.push_back('{16'd13, 8'h10});
        run_descs(0, 0, 0, 50);
        checks++;
        if (!run_ok || bq.size() != 2) begin
            errors++;
            $display("FAIL partial_counts: got ok=%0b beats=%0d expected 1/2", run_ok, bq.size());
        end else begin
            checks++;
            if (bq[0].keep !== 8'hFF || bq[0].last !== 1'b0) begin
                errors++;
                $display("FAIL partial_beat0: got keep=%0h last=%0b expected ff/0", bq[0].keep, bq[0].last);
            end
            checks++;
            if (bq[1].data !== 64'h0000001C1B1A1918 || bq[1].keep !== 8'h1F || bq[1].last !== 1'b1) begin
                errors++;
                $display("FAIL partial_beat1: got %0h/%0h/%0b expected 1c1b1a1918/1f/1", bq[1].data, bq[1].keep, bq[1].last);
            end
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        dq.delete(); dq.push_back('{16'd20, 8'h30});
        run_descs(0, 3, 0, 60);
        checks++;
        if (!run_ok || first_hold != 4 || bq.size() != 3 || hold_err != 0) begin
            errors++;
            $display("FAIL backpressure: got ok=%0b hold=%0d beats=%0d hold_err=%0d expected 1/4/3/0",
                     run_ok, first_hold, bq.size(), hold_err);
        end else begin
            checks++;
            if (bq[2].keep !== 8'h0F || bq[2].data !== model_data(20, 'h30, 2)) begin
                errors++;
                $display("FAIL backpressure_last: got %0h/%0h expected %0h/0f", bq[2].data, bq[2].keep, model_data(20, 'h30, 2));
            end
        end
    endtask

    task automatic test_zero_len();
        @(posedge clk); #1;
        dq.delete(); dq.push_back('{16'd0, 8'h05});
        run_descs(0, 0, 0, 30);
        checks++;
        if (!run_ok || bq.size() != 0 || sq.size() != 1 || pulse_err != 0 || zero_err != 0) begin
            errors++;
            $display("FAIL zero_len_counts: got ok=%0b beats=%0d status=%0d pulse_err=%0d expected 1/0/1/0",
                     run_ok, bq.size(), sq.size(), pulse_err);
        end else begin
            checks++;
            if (sq[0].err !== 1'b1 || sq[0].tag !== 8'h05 || sq[0].len !== 16'd0) begin
                errors++;
                $display("FAIL zero_len_status: got err=%0b tag=%0h len=%0d expected 1/05/0", sq[0].err, sq[0].tag, sq[0].len);
            end
        end
    endtask

    task automatic test_enable();
        int viol;
        @(posedge clk); #1;
        dq.delete(); dq.push_back('{16'd30, 8'hC0});
        run_descs(40, 0, 1, 200);
        checks++;
        if (!run_ok || bq.size() != 4 || sq.size() != 1 || hold_err != 0) begin
            errors++;
            $display("FAIL enable_inflight: got ok=%0b beats=%0d status=%0d hold_err=%0d expected 1/4/1/0",
                     run_ok, bq.size(), sq.size(), hold_err);
        end
        viol = 0;
        s_axis_desc_valid = 1'b1; s_axis_desc_len = 16'd8;
        repeat (8) begin
            @(negedge clk);
            if (s_axis_desc_ready !== 1'b0 || m_axis_tvalid !== 1'b0) viol++;
        end
        s_axis_desc_valid = 1'b0;
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL enable_blocks: got %0d accept/valid cycles expected 0", viol);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (s_axis_desc_ready !== 1'b1) begin
            errors++;
            $display("FAIL enable_restore: got ready=%0b expected 1", s_axis_desc_ready);
        end
    endtask

    task automatic test_back_to_back();
        desc_t ex[$];
        int    ptr, prev_last;
        ex = '{'{16'd8, 8'h01}, '{16'd13, 8'h22}, '{16'd1, 8'hF0}, '{16'd20, 8'h7E}};
        @(posedge clk); #1;
        dq = ex;
        run_descs(0, 0, 0, 100);
        checks++;
        if (!run_ok || bq.size() != 1 + 2 + 1 + 3 || sq.size() != 4) begin
            errors++;
            $display("FAIL b2b_counts: got ok=%0b beats=%0d status=%0d expected 1/7/4", run_ok, bq.size(), sq.size());
        end else begin
            ptr = 0; prev_last = -1;
            foreach (ex[k]) begin
                if (prev_last >= 0) begin
                    checks++;
                    if (bq[ptr].cyc - bq[prev_last].cyc - 1 != 2) begin
                        errors++;
                        $display("FAIL b2b_gap%0d: got %0d idle cycles expected 2", k, bq[ptr].cyc - bq[prev_last].cyc - 1);
                    end
                end
                ptr += model_beats(ex[k].len);
                prev_last = ptr - 1;
            end
        end
    endtask

    task automatic test_random();
        desc_t ex[$];
        int    ptr, nb, ln;
        for (int k = 0; k < 12; k++) begin
            ln = ($urandom_range(4) == 0) ? 0 : $urandom_range(70, 1);
            ex.push_back('{16'(ln), 8'($urandom)});
        end
        @(posedge clk); #1;
        dq = ex;
        run_descs(30, 0, 0, 4000);
        checks++;
        if (!run_ok || sq.size() != 12 || hold_err != 0 || zero_err != 0 || pulse_err != 0) begin
            errors++;
            $display("FAIL random_run: got ok=%0b status=%0d hold_err=%0d zero_err=%0d pulse_err=%0d expected 1/12/0/0/0",
                     run_ok, sq.size(), hold_err, zero_err, pulse_err);
        end else begin
            ptr = 0;
            foreach (ex[k]) begin
                checks++;
                if (sq[k].len !== ex[k].len || sq[k].tag !== ex[k].tag || sq[k].err !== (ex[k].len == 0)) begin
                    errors++;
                    $display("FAIL random_status%0d: got %0d/%0h/%0b expected %0d/%0h/%0b", k,
                             sq[k].len, sq[k].tag, sq[k].err, ex[k].len, ex[k].tag, ex[k].len == 0);
                end
                nb = model_beats(ex[k].len);
                for (int b = 0; b < nb; b++) begin
                    checks++;
                    if (ptr >= bq.size()) begin
                        errors++;
                        $display("FAIL random_beat%0d_%0d: got no beat expected one", k, b);
                    end else if (bq[ptr].data !== model_data(ex[k].len, ex[k].tag, b) ||
                                 bq[ptr].keep !== model_keep(ex[k].len, b) || bq[ptr].last !== (b == nb - 1)) begin
                        errors++;
                        $display("FAIL random_beat%0d_%0d: got %0h/%0h/%0b expected %0h/%0h/%0b", k, b,
                                 bq[ptr].data, bq[ptr].keep, bq[ptr].last,
                                 model_data(ex[k].len, ex[k].tag, b), model_keep(ex[k].len, b), b == nb - 1);
                    end
                    ptr++;
                end
            end
            checks++;
            if (bq.size() != ptr) begin
                errors++;
                $display("FAIL random_total: got %0d beats expected %0d", bq.size(), ptr);
            end
        end
    endtask

    task automatic test_max_len();
        int bad, lasts;
        logic [7:0] tg;
        tg = 8'($urandom);
        @(posedge clk); #1;
        dq.delete(); dq.push_back('{16'hFFFF, tg});
        run_descs(0, 0, 0, 9000);
        checks++;
        if (!run_ok || bq.size() != 8192) begin
            errors++;
            $display("FAIL max_len_beats: got ok=%0b beats=%0d expected 1/8192", run_ok, bq.size());
        end else begin
            bad = 0; lasts = 0;
            foreach (bq[b]) begin
                if (bq[b].data !== model_data(65535, tg, b) || bq[b].keep !== model_keep(65535, b)) bad++;
                if (bq[b].last) lasts++;
            end
            checks++;
            if (bad != 0 || lasts != 1 || bq[8191].last !== 1'b1 || bq[8191].keep !== 8'h7F) begin
                errors++;
                $display("FAIL max_len_data: got bad=%0d lasts=%0d final keep=%0h expected 0/1/7f", bad, lasts, bq[8191].keep);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        @(posedge clk); #1;
        s_axis_desc_valid = 1'b1; s_axis_desc_len = 16'd24; s_axis_desc_tag = 8'h40;
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        s_axis_desc_valid = 1'b0;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tdata[7:0] == 8'h48) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach: got no beat1 expected beat1 within 20 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 0 || m_axis_tdata !== 0 || m_axis_tkeep !== 0 || m_axis_tlast !== 0 ||
            busy !== 0 || s_axis_desc_ready !== 0 || m_axis_desc_status_valid !== 0 ||
            stat_pkt_count !== 0 || stat_byte_count !== 0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got tvalid=%0b tdata=%0h tlast=%0b busy=%0b stat=%0d/%0d expected all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, stat_pkt_count, stat_byte_count);
        end
        m_axis_tready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dq.delete(); dq.push_back('{16'd8, 8'h22});
        run_descs(0, 0, 0, 50);
        checks++;
        if (!run_ok || bq.size() != 1 || sq.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_next: got ok=%0b beats=%0d status=%0d expected 1/1/1", run_ok, bq.size(), sq.size());
        end else begin
            checks++;
            if (bq[0].data !== model_data(8, 'h22, 0) || bq[0].last !== 1'b1 || sq[0].len !== 16'd8) begin
                errors++;
                $display("FAIL reset_mid_clean: got %0h last=%0b status_len=%0d expected %0h/1/8",
                         bq[0].data, bq[0].last, sq[0].len, model_data(8, 'h22, 0));
            end
        end
    endtask

    task automatic test_stats();
        int exp_pkt, exp_bytes;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dq = '{'{16'd8, 8'h01}, '{16'd13, 8'h02}, '{16'd20, 8'h03}, '{16'd0, 8'h04}};
        run_descs(25, 0, 0, 600);
`ifdef PACKET_GENERATOR_STATS_EN
        exp_pkt = 3; exp_bytes = 41;
`else
        exp_pkt = 0; exp_bytes = 0;
`endif
        checks++;
        if (!run_ok || stat_pkt_count !== 32'(exp_pkt) || stat_byte_count !== 32'(exp_bytes)) begin
            errors++;
            $display("FAIL stats: got ok=%0b pkts=%0d bytes=%0d expected 1/%0d/%0d",
                     run_ok, stat_pkt_count, stat_byte_count, exp_pkt, exp_bytes);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        s_axis_desc_valid = 1'b0;
        s_axis_desc_len = '0;
        s_axis_desc_tag = '0;
        m_axis_tready = 1'b0;
        test_reset();
        test_single_beat();
        test_partial_beat();
        test_backpressure();
        test_zero_len();
        test_enable();
        test_back_to_back();
        test_random();
        test_max_len();
        test_reset_mid();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
